// File: rtl/reg_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// reg_wb_arbiter_if : writeback/MDU/scoreboard bus for reg_wb_arbiter
// Revision: 1.0
// ============================================================================
interface reg_wb_arbiter_if;
   logic        i_pipe_we;
   logic [4:0]  i_pipe_rd;
   logic [31:0] i_pipe_data;
   logic        i_mdu_valid;
   logic        o_mdu_ready;
   logic [4:0]  i_mdu_rd;
   logic [31:0] i_mdu_data;
   logic        i_issue_valid;
   logic [4:0]  i_issue_rd;
   logic [4:0]  i_read_rs1;
   logic [4:0]  i_read_rs2;
   logic        o_stall;
   logic [31:0] o_busy;
   logic        o_reg_write;
   logic [4:0]  o_write_rd;
   logic [31:0] o_write_data;

   modport slave (
      input  i_pipe_we, i_pipe_rd, i_pipe_data,
      input  i_mdu_valid, i_mdu_rd, i_mdu_data,
      input  i_issue_valid, i_issue_rd, i_read_rs1, i_read_rs2,
      output o_mdu_ready, o_stall, o_busy,
      output o_reg_write, o_write_rd, o_write_data
   );

   modport master (
      output i_pipe_we, i_pipe_rd, i_pipe_data,
      output i_mdu_valid, i_mdu_rd, i_mdu_data,
      output i_issue_valid, i_issue_rd, i_read_rs1, i_read_rs2,
      input  o_mdu_ready, o_stall, o_busy,
      input  o_reg_write, o_write_rd, o_write_data
   );
endinterface
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// reg_wb_arbiter : single-port register-file writeback arbiter (pipe vs. MDU)
// Revision: 1.0
// ============================================================================
module reg_wb_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   reg_wb_arbiter_if.slave bus
);

   localparam logic [2:0] c_LIMIT = 3'(STARVE_LIMIT);

   logic [4:0]  r_fifo_rd   [2];
   logic [31:0] r_fifo_data [2];
   logic        r_head;
   logic [1:0]  r_count;
   logic [2:0]  r_starve;
   logic [31:0] r_busy;
   logic        r_reg_write;
   logic [4:0]  r_write_rd;
   logic [31:0] r_write_data;

   logic        w_pipe_req;
   logic        w_fifo_ne;
   logic        w_ready;
   logic        w_push;
   logic        w_force;
   logic        w_gnt_fifo;
   logic        w_gnt_pipe;
   logic        w_tail;
   logic [4:0]  w_head_rd;
   logic [31:0] w_head_data;
   logic        w_haz1;
   logic        w_haz2;
   logic [2:0]  w_starve_nxt;
   logic [31:0] w_busy_set;
   logic [31:0] w_busy_clr;

   assign w_pipe_req  = bus.i_pipe_we && (bus.i_pipe_rd != 5'd0);
   assign w_fifo_ne   = (r_count != 2'd0);
   assign w_ready     = (r_count != 2'd2);
   assign w_push      = bus.i_mdu_valid && w_ready && (bus.i_mdu_rd != 5'd0);
   assign w_force     = w_fifo_ne && (r_starve == c_LIMIT);
   assign w_gnt_fifo  = w_force || (w_fifo_ne && !w_pipe_req);
   assign w_gnt_pipe  = w_pipe_req && !w_force;
   assign w_tail      = r_head ^ r_count[0];
   assign w_head_rd   = r_fifo_rd[r_head];
   assign w_head_data = r_fifo_data[r_head];

   assign w_haz1 = (bus.i_read_rs1 != 5'd0) && r_busy[bus.i_read_rs1];
   assign w_haz2 = (bus.i_read_rs2 != 5'd0) && r_busy[bus.i_read_rs2];

   // Counter only advances while an MDU result is waiting behind the pipe
   always_comb begin
      w_starve_nxt = r_starve;
      if (!w_fifo_ne || w_gnt_fifo) begin
         w_starve_nxt = 3'd0;
      end else if (w_gnt_pipe) begin
         w_starve_nxt = r_starve + 3'd1;
      end
   end

   // Set is applied after clear so a re-issue to the retiring rd keeps the bit
   always_comb begin
      w_busy_set = 32'd0;
      w_busy_clr = 32'd0;
      if (bus.i_issue_valid && (bus.i_issue_rd != 5'd0)) begin
         w_busy_set = 32'd1 << bus.i_issue_rd;
      end
      if (w_gnt_fifo) begin
         w_busy_clr = 32'd1 << w_head_rd;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_rd[w_tail]   <= bus.i_mdu_rd;
         r_fifo_data[w_tail] <= bus.i_mdu_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head       <= 1'b0;
         r_count      <= 2'd0;
         r_starve     <= 3'd0;
         r_busy       <= 32'd0;
         r_reg_write  <= 1'b0;
         r_write_rd   <= 5'd0;
         r_write_data <= 32'd0;
      end else begin
         r_count  <= r_count + 2'(w_push) - 2'(w_gnt_fifo);
         r_starve <= w_starve_nxt;
         r_busy   <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
         if (w_gnt_fifo) begin
            r_head <= ~r_head;
         end
         if (w_gnt_fifo) begin
            r_reg_write  <= 1'b1;
            r_write_rd   <= w_head_rd;
            r_write_data <= w_head_data;
         end else if (w_gnt_pipe) begin
            r_reg_write  <= 1'b1;
            r_write_rd   <= bus.i_pipe_rd;
            r_write_data <= bus.i_pipe_data;
         end else begin
            r_reg_write  <= 1'b0;
         end
      end
   end

   assign bus.o_mdu_ready  = w_ready;
   assign bus.o_stall      = w_haz1 || w_haz2 || w_force;
   assign bus.o_busy       = r_busy;
   assign bus.o_reg_write  = r_reg_write;
   assign bus.o_write_rd   = r_write_rd;
   assign bus.o_write_data = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_reg_wb_arbiter : vector table, corner sequences and random vs. model
// Revision: 1.0
// ============================================================================
module tb_reg_wb_arbiter;
   localparam int LIMIT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_wb_arbiter_if bus();
   reg_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
   typedef struct {
      logic pwe; logic [4:0] prd; logic [31:0] pdata;
      logic mv;  logic [4:0] mrd; logic [31:0] mdata;
      logic iv;  logic [4:0] ird; logic [4:0] rs1; logic [4:0] rs2;
      logic e_stall; logic e_ready; logic e_we;
      logic [4:0] e_rd; logic [31:0] e_data; logic [31:0] e_busy;
   } vec_t;

   vec_t        tbl [13];
   ent_t        mq [$];
   ent_t        got [$];
   bit          collect = 1'b0;
   logic [31:0] m_busy;
   int          m_starve;
   logic        m_we;
   logic [4:0]  m_wrd;
   logic [31:0] m_wdata;
   logic        m_force, m_ready, m_stall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   task automatic idle_inputs();
      bus.i_pipe_we = 1'b0; bus.i_pipe_rd = 5'd0; bus.i_pipe_data = 32'd0;
      bus.i_mdu_valid = 1'b0; bus.i_mdu_rd = 5'd0; bus.i_mdu_data = 32'd0;
      bus.i_issue_valid = 1'b0; bus.i_issue_rd = 5'd0;
      bus.i_read_rs1 = 5'd0; bus.i_read_rs2 = 5'd0;
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy = 32'd0; m_starve = 0; m_we = 1'b0; m_wrd = 5'd0; m_wdata = 32'd0;
   endtask

   // Quantities visible before the edge: readiness, forced grant, stall
   task automatic model_pre();
      m_force = (mq.size() != 0) && (m_starve == LIMIT);
      m_ready = (mq.size() < 2);
      m_stall = m_force
             || ((bus.i_read_rs1 != 5'd0) && m_busy[bus.i_read_rs1])
             || ((bus.i_read_rs2 != 5'd0) && m_busy[bus.i_read_rs2]);
   endtask

   task automatic model_edge();
      bit   preq;
      bit   had;
      bit   acc;
      ent_t e;
      preq = bus.i_pipe_we && (bus.i_pipe_rd != 5'd0);
      had  = (mq.size() != 0);
      acc  = bus.i_mdu_valid && m_ready && (bus.i_mdu_rd != 5'd0);
      if (m_force || (!preq && had)) begin
         e = mq.pop_front();
         m_we = 1'b1; m_wrd = e.rd; m_wdata = e.data;
         m_busy[e.rd] = 1'b0;
         m_starve = 0;
      end else if (preq) begin
         m_we = 1'b1; m_wrd = bus.i_pipe_rd; m_wdata = bus.i_pipe_data;
         m_starve = had ? m_starve + 1 : 0;
      end else begin
         m_we = 1'b0;
         m_starve = 0;
      end
      if (bus.i_issue_valid && (bus.i_issue_rd != 5'd0)) m_busy[bus.i_issue_rd] = 1'b1;
      if (acc) mq.push_back({bus.i_mdu_rd, bus.i_mdu_data});
   endtask

   // One clock with inputs already driven; checks every output against the model
   task automatic cyc();
      model_pre();
      #1;
      chk("stall", 32'(bus.o_stall), 32'(m_stall));
      chk("mdu_ready", 32'(bus.o_mdu_ready), 32'(m_ready));
      model_edge();
      @(posedge clk); #1;
      chk("reg_write", 32'(bus.o_reg_write), 32'(m_we));
      chk("write_rd", 32'(bus.o_write_rd), 32'(m_wrd));
      chk("write_data", bus.o_write_data, m_wdata);
      chk("busy", bus.o_busy, m_busy);
      if (collect && bus.o_reg_write && (bus.o_write_rd >= 5'd10))
         got.push_back({bus.o_write_rd, bus.o_write_data});
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit acc;
      bit done;
      tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0};
      tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0,
                  1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h00000080};
      tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd0,
                  1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h00000080};
      tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b1, 1'b1, 5'd7, 32'h12345678, 32'h0};
      tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0,
                  1'b0, 1'b1, 1'b0, 5'd7, 32'h12345678, 32'h00000200};
      tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9,
                  1'b1, 1'b1, 1'b0, 5'd7, 32'h12345678, 32'h00000200};
      tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b1, 1'b0, 5'd7, 32'h12345678, 32'h00000200};
      tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b1, 1'b0, 5'd7, 32'h12345678, 32'h00000200};
      tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b1, 1'b0, 5'd7, 32'h12345678, 32'h00000200};
      tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hAAAA5555, 1'b0, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b1, 1'b0, 5'd7, 32'h12345678, 32'h00000200};
      tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0,
                  1'b0, 1'b1, 1'b1, 5'd9, 32'hAAAA5555, 32'h00000200};
      tbl[12] = '{1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0,
                  1'b1, 1'b1, 1'b1, 5'd3, 32'h00000033, 32'h00000200};

      idle_inputs();
      #2;
      chk("rst_reg_write", 32'(bus.o_reg_write), 32'd0);
      chk("rst_write_rd", 32'(bus.o_write_rd), 32'd0);
      chk("rst_write_data", bus.o_write_data, 32'd0);
      chk("rst_busy", bus.o_busy, 32'd0);
      chk("rst_mdu_ready", 32'(bus.o_mdu_ready), 32'd1);
      chk("rst_stall", 32'(bus.o_stall), 32'd0);

      // Directed vector table from a fresh reset
      do_reset();
      for (int i = 0; i < 13; i++) begin
         bus.i_pipe_we = tbl[i].pwe; bus.i_pipe_rd = tbl[i].prd; bus.i_pipe_data = tbl[i].pdata;
         bus.i_mdu_valid = tbl[i].mv; bus.i_mdu_rd = tbl[i].mrd; bus.i_mdu_data = tbl[i].mdata;
         bus.i_issue_valid = tbl[i].iv; bus.i_issue_rd = tbl[i].ird;
         bus.i_read_rs1 = tbl[i].rs1; bus.i_read_rs2 = tbl[i].rs2;
         #1;
         chk($sformatf("tbl%0d_stall", i), 32'(bus.o_stall), 32'(tbl[i].e_stall));
         chk($sformatf("tbl%0d_ready", i), 32'(bus.o_mdu_ready), 32'(tbl[i].e_ready));
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_we", i), 32'(bus.o_reg_write), 32'(tbl[i].e_we));
         chk($sformatf("tbl%0d_rd", i), 32'(bus.o_write_rd), 32'(tbl[i].e_rd));
         chk($sformatf("tbl%0d_data", i), bus.o_write_data, tbl[i].e_data);
         chk($sformatf("tbl%0d_busy", i), bus.o_busy, tbl[i].e_busy);
      end

      // Starvation: one queued MDU result against a continuous pipe stream
      do_reset();
      bus.i_pipe_we = 1'b1; bus.i_pipe_rd = 5'd1; bus.i_pipe_data = 32'd100;
      bus.i_mdu_valid = 1'b1; bus.i_mdu_rd = 5'd4; bus.i_mdu_data = 32'h44;
      cyc();
      chk("starve_first_pipe", bus.o_write_data, 32'd100);
      bus.i_mdu_valid = 1'b0;
      for (int k = 1; k <= LIMIT; k++) begin
         bus.i_pipe_data = 32'(100 + k);
         cyc();
         chk($sformatf("starve_pipe%0d", k), bus.o_write_data, 32'(100 + k));
      end
      bus.i_pipe_data = 32'd105;
      #1;
      chk("starve_forced_stall", 32'(bus.o_stall), 32'd1);
      cyc();
      chk("starve_forced_rd", 32'(bus.o_write_rd), 32'd4);
      chk("starve_forced_data", bus.o_write_data, 32'h44);
      cyc();
      chk("starve_held_pipe_rd", 32'(bus.o_write_rd), 32'd1);
      chk("starve_held_pipe_data", bus.o_write_data, 32'd105);

      // Full FIFO: three results while the pipe keeps writing
      do_reset();
      got.delete();
      collect = 1'b1;
      bus.i_pipe_we = 1'b1; bus.i_pipe_rd = 5'd2; bus.i_pipe_data = 32'h200;
      bus.i_mdu_valid = 1'b1; bus.i_mdu_rd = 5'd10; bus.i_mdu_data = 32'hA1;
      cyc();
      bus.i_mdu_rd = 5'd11; bus.i_mdu_data = 32'hA2;
      cyc();
      chk("full_ready_low", 32'(bus.o_mdu_ready), 32'd0);
      bus.i_mdu_rd = 5'd12; bus.i_mdu_data = 32'hA3;
      done = 1'b0;
      for (int k = 0; k < 12 && !done; k++) begin
         acc = bus.o_mdu_ready;
         cyc();
         done = acc;
      end
      if (!done) chk("full_third_accept_timeout", 32'd0, 32'd1);
      idle_inputs();
      repeat (4) cyc();
      collect = 1'b0;
      chk("full_count", 32'(got.size()), 32'd3);
      if (got.size() == 3) begin
         chk("full_order0", 32'(got[0]), 32'({5'd10, 32'hA1}));
         chk("full_order1", 32'(got[1]), 32'({5'd11, 32'hA2}));
         chk("full_order2", 32'(got[2]), 32'({5'd12, 32'hA3}));
      end

      // Reset asserted with two queued results and a busy register
      do_reset();
      bus.i_pipe_we = 1'b1; bus.i_pipe_rd = 5'd2; bus.i_pipe_data = 32'h77;
      bus.i_issue_valid = 1'b1; bus.i_issue_rd = 5'd3;
      cyc();
      bus.i_issue_valid = 1'b0;
      bus.i_mdu_valid = 1'b1; bus.i_mdu_rd = 5'd3; bus.i_mdu_data = 32'hD3;
      cyc();
      bus.i_mdu_rd = 5'd6; bus.i_mdu_data = 32'hD6;
      cyc();
      chk("midrst_full", 32'(bus.o_mdu_ready), 32'd0);
      chk("midrst_busy3", 32'(bus.o_busy[3]), 32'd1);
      idle_inputs();
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_reg_write", 32'(bus.o_reg_write), 32'd0);
      chk("midrst_write_rd", 32'(bus.o_write_rd), 32'd0);
      chk("midrst_write_data", bus.o_write_data, 32'd0);
      chk("midrst_busy", bus.o_busy, 32'd0);
      chk("midrst_ready", 32'(bus.o_mdu_ready), 32'd1);
      chk("midrst_stall", 32'(bus.o_stall), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc();
      chk("midrst_no_write", 32'(bus.o_reg_write), 32'd0);

      // Random traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         bus.i_pipe_we     = ($urandom_range(0, 9) < 6);
         bus.i_pipe_rd     = 5'($urandom_range(0, 7));
         bus.i_pipe_data   = $urandom;
         bus.i_mdu_valid   = ($urandom_range(0, 9) < 4);
         bus.i_mdu_rd      = 5'($urandom_range(0, 7));
         bus.i_mdu_data    = $urandom;
         bus.i_issue_valid = ($urandom_range(0, 9) < 3);
         bus.i_issue_rd    = 5'($urandom_range(0, 7));
         bus.i_read_rs1    = 5'($urandom_range(0, 7));
         bus.i_read_rs2    = 5'($urandom_range(0, 7));
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive lost arbitrations before a forced MDU grant (range 1..7).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset; reset is asynchronous and active-low.
REQ-004 SHALL have port i_pipe_we, input, 1, pipeline writeback request.
REQ-005 SHALL have port i_pipe_rd, input, 5, pipeline destination register.
REQ-006 SHALL have port i_pipe_data, input, 32, pipeline writeback data.
REQ-007 SHALL have port i_mdu_valid, input, 1, multi-cycle unit (MDU) result valid.
REQ-008 SHALL have port o_mdu_ready, output, 1, MDU result accepted this cycle when high with i_mdu_valid.
REQ-009 SHALL have ports i_mdu_rd, input, 5 and i_mdu_data, input, 32: MDU destination and result.
REQ-010 SHALL have ports i_issue_valid, input, 1 and i_issue_rd, input, 5: MDU op issued, marks rd busy.
REQ-011 SHALL have ports i_read_rs1 and i_read_rs2, input, 5 each: decode-stage source registers.
REQ-012 SHALL have port o_stall, output, 1, combinational, freezes decode and holds the pipeline writeback.
REQ-013 SHALL have port o_busy, output, 32, scoreboard bit per register.
REQ-014 SHALL have ports o_reg_write, output, 1; o_write_rd, output, 5; o_write_data, output, 32: registered single write port to the register file.

Function
REQ-015 SHALL buffer accepted MDU results in a 2-entry in-order FIFO; o_mdu_ready = FIFO not full (from registered count only, no combinational path from grant).
REQ-016 SHALL accept an MDU result on an edge where i_mdu_valid and o_mdu_ready are high; rd=0 results are accepted and discarded (never enqueued).
REQ-017 SHALL treat i_pipe_we with i_pipe_rd=0 as no request.
REQ-018 SHALL arbitrate each cycle: forced grant -> FIFO head; else pipe request -> pipe; else FIFO non-empty -> FIFO head; else no grant.
REQ-019 SHALL maintain a starve counter: increments when FIFO non-empty and pipe wins; clears on any FIFO grant or when FIFO empty; forced grant active in the cycle counter == STARVE_LIMIT.
REQ-020 SHALL register the winner: o_reg_write=1, o_write_rd/o_write_data = winner values on the next edge; no grant -> o_reg_write=0, o_write_rd/o_write_data hold previous values.
REQ-021 SHALL pop the FIFO on the same edge a FIFO grant is registered; simultaneous push and pop with FIFO full SHALL NOT occur (ready low) and with 1 entry SHALL leave count at 1.
REQ-022 SHALL set o_busy[i_issue_rd] on an edge with i_issue_valid and i_issue_rd != 0; o_busy[0] is always 0.
REQ-023 SHALL clear o_busy[rd] on the edge the FIFO grant for rd is registered; set and clear of the same rd on one edge -> bit stays set.
REQ-024 SHALL assert o_stall when (i_read_rs1 != 0 and o_busy[i_read_rs1]) or (i_read_rs2 != 0 and o_busy[i_read_rs2]) or forced grant active.
REQ-025 SHALL NOT drop a pipe request during a forced grant; upstream holds it under o_stall and it wins the next cycle.
REQ-026 Minimum latency: MDU accept at edge E -> o_reg_write high after edge E+1; pipe request at cycle C -> o_reg_write high after the edge ending C.

Reset
REQ-027 SHALL, while i_rst_n=0, asynchronously force: FIFO empty, starve counter 0, o_busy=0, o_reg_write=0, o_write_rd=0, o_write_data=0; thus o_mdu_ready=1 and o_stall=0 (absent hazard inputs).
REQ-028 SHALL discard FIFO contents and busy bits on reset assertion mid-operation; no write issues on the first edge after release.

Verification
REQ-029 Pipe only: pipe_we=1, rd=5, data=0xDEADBEEF -> next cycle o_reg_write=1, rd=5, data=0xDEADBEEF; rd=0 -> o_reg_write=0.
REQ-030 MDU path: issue rd=7, then MDU valid rd=7, data=0x12345678, pipe idle -> o_busy[7]=1 until write; o_reg_write after E+1 with rd=7; o_busy[7]=0 next cycle.
REQ-031 Hazard: o_busy[9]=1, i_read_rs2=9 -> o_stall=1; i_read_rs1=0 with o_busy[0] queried -> o_stall=0.
REQ-032 Starvation: FIFO holds 1 entry, pipe_we=1 every cycle, STARVE_LIMIT=4 -> 4 pipe writes, then FIFO write with o_stall=1 for one cycle, then held pipe write.
REQ-033 Full FIFO: 2 MDU results while pipe busy -> o_mdu_ready=0; third valid held until a pop; no result lost or reordered.
REQ-034 Reset mid-op: FIFO 2 entries, o_busy[3]=1, assert i_rst_n=0 -> all outputs 0 immediately, o_mdu_ready=1, no write after release.
